hs32_prefetch: RTL

Parametrised next-generation instruction fetch unit for the hs32 core. It issues sequential fetch requests to the memory arbiter and buffers returned instructions, each tagged with its own address, in a DEPTH-entry FIFO. It presents them to decode with a valid/take handshake. Flush redirects to a new PC and discards all queued and in-flight data.

---
 rtl/hs32_prefetch.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/hs32_prefetch.sv
// hs32 instruction prefetch unit.
// Issues sequential fetch requests to the memory arbiter and queues the
// returned instructions, each tagged with its fetch address, in a DEPTH-entry
// FIFO that decode drains with a valid/take handshake. A flush redirects the
// fetch PC and throws away everything queued or still in flight.
module hs32_prefetch #(
    parameter int             DW       = 32,
    parameter int             AW       = 32,
    parameter int             PBITS    = 2,
    parameter int             DEPTH    = 4,
    parameter int             PC_INC   = 4,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [AW-1:0]    addr,
    output logic             reqm,
    input  logic [DW-1:0]    dtr,
    input  logic             ackm,
    output logic [DW-1:0]    instd,
    output logic [AW-1:0]    pcd,
    output logic             ackd,
    input  logic             reqd,
    input  logic [AW-1:0]    newpc,
    input  logic             flush,
    output logic [PBITS:0]   fill
);

    localparam logic [AW-1:0]    INC     = AW'(PC_INC);
    localparam logic [PBITS+1:0] DEPTH_X = (PBITS+2)'(DEPTH);
    localparam logic [PBITS:0]   PTR_ONE = (PBITS+1)'(1);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t             state, state_n;
    logic [AW-1:0]      pc, pc_n;
    logic [AW-1:0]      addr_r, addr_n;
    logic               reqm_r, reqm_n;
    logic [PBITS:0]     wp, rp;
    logic [PBITS:0]     fill_w;
    logic [PBITS+1:0]   fill_nx;
    logic               ackd_w;
    logic               push, pop, clr;

    // Data storage carries no reset; only the pointers qualify its contents.
    logic [DW-1:0]      mem_i [DEPTH];
    logic [AW-1:0]      mem_p [DEPTH];

    // Fetch addresses wrap modulo 2**AW.
    function automatic logic [AW-1:0] pc_step(input logic [AW-1:0] a);
        return a + INC;
    endfunction

    assign fill_w = wp - rp;
    assign ackd_w = (fill_w != '0);

    // Next-state and next-request decode; flush always wins over push and pop.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        addr_n  = addr_r;
        reqm_n  = reqm_r;
        push    = 1'b0;
        clr     = flush;
        pop     = reqd && ackd_w && !flush;
        fill_nx = '0;
        case (state)
            IDLE: begin
                if (flush) begin
                    pc_n = newpc;
                end else if ({1'b0, fill_w} < DEPTH_X) begin
                    reqm_n  = 1'b1;
                    addr_n  = pc;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (ackm) begin
                    if (flush) begin
                        // Returned word belongs to the old stream: drop it.
                        pc_n    = newpc;
                        reqm_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        push    = 1'b1;
                        pc_n    = pc_step(addr_r);
                        fill_nx = {1'b0, fill_w} + (PBITS+2)'(1)
                                  - {{(PBITS+1){1'b0}}, pop};
                        // Keep streaming back-to-back while room remains.
                        if (fill_nx < DEPTH_X) begin
                            addr_n = pc_step(addr_r);
                        end else begin
                            reqm_n  = 1'b0;
                            state_n = IDLE;
                        end
                    end
                end else if (flush) begin
                    // Request cannot be aborted; wait for its ack in DRAIN.
                    pc_n    = newpc;
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (flush) begin
                    pc_n = newpc;
                end
                if (ackm) begin
                    reqm_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Control state: FSM, fetch PC, arbiter request and FIFO pointers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            addr_r <= '0;
            reqm_r <= 1'b0;
            wp     <= '0;
            rp     <= '0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            addr_r <= addr_n;
            reqm_r <= reqm_n;
            if (clr) begin
                wp <= '0;
                rp <= '0;
            end else begin
                if (push) wp <= wp + PTR_ONE;
                if (pop)  rp <= rp + PTR_ONE;
            end
        end
    end

    // FIFO write: instruction word together with the address it came from.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_i[wp[PBITS-1:0]] <= dtr;
            mem_p[wp[PBITS-1:0]] <= addr_r;
        end
    end

    assign addr  = addr_r;
    assign reqm  = reqm_r;
    assign instd = mem_i[rp[PBITS-1:0]];
    assign pcd   = mem_p[rp[PBITS-1:0]];
    assign ackd  = ackd_w;
    assign fill  = fill_w;

endmodule
